// File: rtl/qft_pkg.sv
// Shared types and parameter helpers for the QFT operation sequencer.
package qft_pkg;

    typedef enum logic [1:0] {
        OP_END  = 2'b00,
        OP_QFT  = 2'b01,
        OP_ABS  = 2'b10,
        OP_RSVD = 2'b11
    } seq_op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    // Wait budget that comfortably covers the slowest (QFT) round trip.
    function automatic int default_timeout(input int n);
        return 4 * n + 8;
    endfunction

    function automatic int timer_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Small program store: one opcode per slot, cleared to END on reset.
module seq_prog_mem
    import qft_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [1:0]               wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [1:0]               rdata
);

    logic [1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= OP_END;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/qft_sequencer.sv
// Steps through a loaded program, issuing one start pulse per operation and
// waiting for the controller's update_state completion before moving on.
module qft_sequencer
    import qft_pkg::*;
#(
    parameter int N       = 2,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = default_timeout(N)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [1:0]               prog_op,
    input  logic                     run,
    input  logic                     update_state,
    output logic                     strt_qft,
    output logic                     strt_abs,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH)-1:0] step_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = timer_width(TIMEOUT);
    localparam logic [AW-1:0] LAST_PC    = AW'(DEPTH - 1);
    localparam logic [TW-1:0] LAST_TICK  = TW'(TIMEOUT - 1);

    seq_state_t    state, state_nxt;
    seq_op_t       op_q, op_nxt;
    logic [AW-1:0] pc, pc_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          err_q, err_nxt;
    logic [1:0]    mem_op;

    // Writes are only honoured while idle so a running program cannot change.
    seq_prog_mem #(.DEPTH(DEPTH)) u_prog (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (prog_we && (state == ST_IDLE)),
        .waddr (prog_addr),
        .wdata (prog_op),
        .raddr (pc),
        .rdata (mem_op)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_q  <= OP_END;
            pc    <= '0;
            timer <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            op_q  <= op_nxt;
            pc    <= pc_nxt;
            timer <= timer_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        pc_nxt    = pc;
        timer_nxt = timer;
        err_nxt   = err_q;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    pc_nxt    = '0;
                    err_nxt   = 1'b0;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                op_nxt = seq_op_t'(mem_op);
                if (mem_op == OP_QFT || mem_op == OP_ABS) begin
                    state_nxt = ST_ISSUE;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_ISSUE: begin
                timer_nxt = '0;
                state_nxt = ST_WAIT;
            end
            // Completion is checked before the timeout so a coincident pulse wins.
            ST_WAIT: begin
                if (update_state) begin
                    if (pc == LAST_PC) begin
                        state_nxt = ST_DONE;
                    end else begin
                        pc_nxt    = pc + AW'(1);
                        state_nxt = ST_FETCH;
                    end
                end else if (timer == LAST_TICK) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign strt_qft = (state == ST_ISSUE) && (op_q == OP_QFT);
    assign strt_abs = (state == ST_ISSUE) && (op_q == OP_ABS);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign err      = err_q;
    assign step_idx = pc;

endmodule

// File: tb/tb_qft_sequencer.sv
// Self-checking bench for qft_sequencer with a behavioural controller responder
// and an event-timeline reference model.
module tb_qft_sequencer;

    localparam int N       = 2;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam logic [1:0] E = 2'd0, Q = 2'd1, A = 2'd2, R = 2'd3;

    logic       clk = 1'b0, rst_n = 1'b0, prog_we = 1'b0, run = 1'b0;
    logic [1:0] prog_addr = '0, prog_op = '0;
    logic       update_state, strt_qft, strt_abs, busy, done, err;
    logic [1:0] step_idx;

    logic resp_upd = 1'b0, force_upd = 1'b0;
    bit   qen = 1'b1, aen = 1'b1;
    assign update_state = resp_upd | force_upd;

    int   cyc = 0, run_cyc = 0, resp_at = -100, done_cyc = 0, step_at_done = 0;
    bit   done_seen = 1'b0;
    logic err_at_done = 1'b0;
    int   ev_q[$], exp_q[$];
    int   n_cmp = 0, n_fail = 0;

    typedef struct {
        logic [7:0] prog;
        int         done_off;
        int         n_strobe;
        int         step;
    } vec_t;
    vec_t vecs[7];

    qft_sequencer #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_op      (prog_op),
        .run          (run),
        .update_state (update_state),
        .strt_qft     (strt_qft),
        .strt_abs     (strt_abs),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .step_idx     (step_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Controller stand-in: answers ABS after 2 cycles and QFT after 1+2N cycles.
    always @(negedge clk) begin
        resp_upd = (cyc == resp_at);
        if (strt_qft) begin
            ev_q.push_back((cyc - run_cyc) * 4 + 1);
            if (qen) resp_at = cyc + 1 + 2 * N;
        end
        if (strt_abs) begin
            ev_q.push_back((cyc - run_cyc) * 4 + 2);
            if (aen) resp_at = cyc + 2;
        end
        if (done) begin
            done_seen    = 1'b1;
            done_cyc     = cyc;
            err_at_done  = err;
            step_at_done = int'(step_idx);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] mk(input logic [1:0] o0, o1, o2, o3);
        return {o3, o2, o1, o0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Timeline model: cycles are offsets from the run pulse, events encoded as offset*4+kind.
    task automatic modelRun(input logic [7:0] p, input bit q_ok, input bit a_ok,
                            output int d, output int st, output bit e);
        int c, u, lat;
        logic [1:0] op;
        bit answers;
        exp_q.delete();
        c = 1; e = 1'b0; d = 0; st = 0;
        for (int i = 0; i < DEPTH; i++) begin
            op = p[2*i +: 2];
            st = i;
            if (op == E || op == R) begin
                d = c + 1;
                return;
            end
            exp_q.push_back((c + 1) * 4 + int'(op));
            answers = (op == Q) ? q_ok : a_ok;
            if (!answers) begin
                e = 1'b1;
                d = c + 2 + TIMEOUT;
                return;
            end
            lat = (op == Q) ? 1 + 2 * N : 2;
            u = c + 1 + lat;
            if (i == DEPTH - 1) begin
                d = u + 1;
                return;
            end
            c = u + 1;
        end
    endtask

    task automatic loadProgram(input logic [7:0] p);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk); #1;
            prog_we   = 1'b1;
            prog_addr = 2'(i);
            prog_op   = p[2*i +: 2];
        end
        @(negedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic startRun();
        @(negedge clk); #1;
        ev_q.delete();
        done_seen = 1'b0;
        run_cyc   = cyc;
        run       = 1'b1;
        @(negedge clk); #1;
        run = 1'b0;
    endtask

    task automatic waitDone(input int bound);
        for (int k = 0; k < bound; k++) begin
            if (done_seen) break;
            @(negedge clk); #1;
        end
        checkOutput("done_seen", done_seen, 1);
    endtask

    task automatic checkRun(input string tag, input logic [7:0] p);
        int d, st;
        bit e;
        modelRun(p, qen, aen, d, st, e);
        checkOutput({tag, "_done_off"}, done_cyc - run_cyc, d);
        checkOutput({tag, "_err"}, err_at_done, e);
        checkOutput({tag, "_step"}, step_at_done, st);
        checkOutput({tag, "_n_strobe"}, ev_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checkOutput({tag, "_strobe"}, (i < ev_q.size()) ? ev_q[i] : -1, exp_q[i]);
        end
        @(negedge clk); #1;
        checkOutput({tag, "_busy_after"}, busy, 0);
        checkOutput({tag, "_done_after"}, done, 0);
        checkOutput({tag, "_err_hold"}, err, e);
    endtask

    task automatic applyStimulus(input logic [7:0] p, input string tag);
        startRun();
        waitDone(200);
        checkRun(tag, p);
    endtask

    task automatic checkAllLow(input string tag);
        checkOutput({tag, "_strt_qft"}, strt_qft, 0);
        checkOutput({tag, "_strt_abs"}, strt_abs, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_step_idx"}, step_idx, 0);
    endtask

    initial begin
        logic [7:0] p;
        vecs[0] = '{mk(Q, A, E, E), 13, 2, 2};
        vecs[1] = '{mk(A, A, A, A), 17, 4, 3};
        vecs[2] = '{mk(E, E, E, E),  2, 0, 0};
        vecs[3] = '{mk(R, Q, Q, Q),  2, 0, 0};
        vecs[4] = '{mk(A, R, Q, Q),  6, 1, 1};
        vecs[5] = '{mk(Q, Q, Q, Q), 29, 4, 3};
        vecs[6] = '{mk(A, Q, E, A), 13, 2, 2};

        #3;
        checkAllLow("reset");
        #9 rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            qen = 1'b1; aen = 1'b1;
            loadProgram(vecs[i].prog);
            applyStimulus(vecs[i].prog, "vec");
            checkOutput("vec_tbl_done_off", done_cyc - run_cyc, vecs[i].done_off);
            checkOutput("vec_tbl_strobes", ev_q.size(), vecs[i].n_strobe);
            checkOutput("vec_tbl_step", step_at_done, vecs[i].step);
        end

        $display("[TB] timeout with silent controller");
        p = mk(Q, E, E, E);
        loadProgram(p);
        qen = 1'b0;
        applyStimulus(p, "timeout");
        checkOutput("timeout_tbl_done_off", done_cyc - run_cyc, 19);
        qen = 1'b1;
        startRun();
        checkOutput("rerun_err_clear", err, 0);
        waitDone(200);
        checkRun("rerun", p);

        $display("[TB] run/prog_we/update_state while busy");
        p = mk(Q, A, E, E);
        loadProgram(p);
        startRun();
        force_upd = 1'b1;
        checkOutput("fetch_busy", busy, 1);
        @(negedge clk); #1;
        force_upd = 1'b0;
        repeat (2) begin @(negedge clk); #1; end
        run = 1'b1; prog_we = 1'b1; prog_addr = 2'd0; prog_op = A;
        @(negedge clk); #1;
        run = 1'b0; prog_we = 1'b0;
        waitDone(200);
        checkRun("busy_ignore", p);
        applyStimulus(p, "slot0_kept");

        $display("[TB] asynchronous reset mid-WAIT");
        p = mk(Q, Q, E, E);
        loadProgram(p);
        startRun();
        repeat (10) begin @(negedge clk); #1; end
        checkOutput("pre_reset_step", step_idx, 1);
        checkOutput("pre_reset_busy", busy, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkAllLow("midreset");
        resp_at = -100;
        #4 rst_n = 1'b1;
        applyStimulus(8'h00, "after_reset");

        $display("[TB] completion coincides with last timer tick");
        p = mk(Q, A, E, E);
        loadProgram(p);
        qen = 1'b0; aen = 1'b1;
        startRun();
        repeat (17) begin @(negedge clk); #1; end
        force_upd = 1'b1;
        @(negedge clk); #1;
        force_upd = 1'b0;
        checkOutput("edge_busy", busy, 1);
        checkOutput("edge_err", err, 0);
        checkOutput("edge_step", step_idx, 1);
        checkOutput("edge_done", done, 0);
        @(negedge clk); #1;
        checkOutput("edge_strt_abs", strt_abs, 1);
        waitDone(200);
        checkOutput("edge_done_off", done_cyc - run_cyc, 24);
        checkOutput("edge_err_at_done", err_at_done, 0);
        checkOutput("edge_step_at_done", step_at_done, 2);
        checkOutput("edge_n_strobe", ev_q.size(), 2);

        $display("[TB] randomized programs");
        for (int i = 0; i < 20; i++) begin
            p   = 8'($urandom);
            qen = ($urandom_range(0, 4) != 0);
            aen = ($urandom_range(0, 4) != 0);
            loadProgram(p);
            applyStimulus(p, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
